// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and counter sizing for serial_addsub_unit
package addsub_pkg;
    typedef enum logic {IDLE, COMPUTE} state_t;
    // Digit counter width: enough to count WIDTH/DIGIT digits, never zero bits wide.
    function automatic int cnt_width(input int width, input int digit);
        return ($clog2(width / digit) > 1) ? $clog2(width / digit) : 1;
    endfunction
endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder slice
//   a, b     : DIGIT-bit addends
//   cin      : carry in
//   s        : DIGIT-bit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (feeds the signed-overflow flag)
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    // The sum bit is a ^ b ^ carry-in, so the carry into the top bit falls out of it.
    assign c_msb_in = a[DIGIT-1] ^ b[DIGIT-1] ^ s[DIGIT-1];
endmodule

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: multi-cycle A+B / A-B processing DIGIT bits per clock
//   Clk, Reset : clock, synchronous active-high reset
//   LoadB      : load SW into operand B (any state)
//   Run        : rising edge starts an operation, capturing A from SW
//   Sub        : 0 = A+B, 1 = A-B, sampled on the Run edge
//   SW         : switch operand
//   Sum, CO, V : registered result, carry-out (no-borrow for Sub), signed overflow
//   Busy, Done : computing flag, one-cycle completion pulse
// Define SERIAL_ADDSUB_OVF_EN to compute V; otherwise V is tied to 0.
module serial_addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadB,
    input  logic             Run,
    input  logic             Sub,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             V,
    output logic             Busy,
    output logic             Done
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);

    state_t           r_state;
    logic             r_run_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_w;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_busy;
    logic             r_done;
    logic [DIGIT-1:0] w_s;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             w_c_msb;
    logic             r_v;
    assign V = r_v;
`else
    logic             w_c_msb_unused;
    assign V = 1'b0;
`endif

    // New digit enters at the top; after N digits the word is in place.
    assign w_acc_next = WIDTH'({w_s, r_acc} >> DIGIT);
    assign w_last     = r_cnt == CW'(N - 1);

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a        (r_a[DIGIT-1:0]),
        .b        (r_b_w[DIGIT-1:0]),
        .cin      (r_carry),
        .s        (w_s),
        .cout     (w_cout),
`ifdef SERIAL_ADDSUB_OVF_EN
        .c_msb_in (w_c_msb)
`else
        .c_msb_in (w_c_msb_unused)
`endif
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_run_q <= 1'b0;
            r_b     <= '0;
            r_a     <= '0;
            r_b_w   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_v     <= 1'b0;
`endif
        end else begin
            r_run_q <= Run;
            r_done  <= 1'b0;
            if (LoadB)
                r_b <= SW;
            if (r_state == IDLE) begin
                if (Run && !r_run_q) begin
                    r_a     <= SW;
                    r_b_w   <= Sub ? ~r_b : r_b;
                    r_carry <= Sub;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= COMPUTE;
                end
            end else begin
                r_a     <= r_a >> DIGIT;
                r_b_w   <= r_b_w >> DIGIT;
                r_carry <= w_cout;
                r_acc   <= w_acc_next;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum   <= w_acc_next;
                    r_co    <= w_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    r_v     <= w_c_msb ^ w_cout;
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            end
        end
    end

    assign Sum  = r_sum;
    assign CO   = r_co;
    assign Busy = r_busy;
    assign Done = r_done;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb_serial_addsub_unit: scoreboard bench for DIGIT=4, DIGIT=1 and DIGIT=16 instances
module tb_serial_addsub_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        LoadB = 1'b0;
    logic        Run = 1'b0;
    logic        Sub = 1'b0;
    logic [15:0] SW = '0;
    logic [15:0] sum [3];
    logic        co [3];
    logic        v [3];
    logic        busy [3];
    logic        done [3];
    logic [17:0] q0 [$];
    logic [17:0] q1 [$];
    logic [17:0] q2 [$];
    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Sub(Sub), .SW(SW),
        .Sum(sum[0]), .CO(co[0]), .V(v[0]), .Busy(busy[0]), .Done(done[0]));
    serial_addsub_unit #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Sub(Sub), .SW(SW),
        .Sum(sum[1]), .CO(co[1]), .V(v[1]), .Busy(busy[1]), .Done(done[1]));
    serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Sub(Sub), .SW(SW),
        .Sum(sum[2]), .CO(co[2]), .V(v[2]), .Busy(busy[2]), .Done(done[2]));

    // Reference: {V, CO, Sum} of A + (Sub ? ~B : B) + Sub.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] bb;
        logic [16:0] f;
        logic        ov;
        bb = s ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + {16'b0, s};
        ov = (a[15] == bb[15]) && (f[15] != a[15]);
`ifndef SERIAL_ADDSUB_OVF_EN
        ov = 1'b0;
`endif
        return {ov, f[16], f[15:0]};
    endfunction

    task automatic load_b(input logic [15:0] b);
        @(negedge Clk);
        LoadB = 1'b1;
        SW = b;
        @(negedge Clk);
        LoadB = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Reset = 1'b1;
        Run = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Run low for a cycle, then a Run edge with A/Sub; SW and Sub are scrambled once computing.
    // Returns cycles from the sampling edge to Done on instance k (-1 on timeout) and {Busy,V,CO,Sum} then.
    task automatic run_op(input int k, input logic [15:0] a, input logic s,
                          output int lat, output logic [18:0] obs);
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Run = 1'b1;
        SW = a;
        Sub = s;
        lat = -1;
        obs = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (c == 1) begin
                Run = 1'b0;
                SW = 16'($urandom);
                Sub = ~s;
            end
            if (done[k]) begin
                lat = c;
                obs = {busy[k], v[k], co[k], sum[k]};
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (sum[0] !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum[0]); end
        checks++; if (co[0] !== 1'b0) begin failures++; $display("FAIL reset_co got=%b exp=0", co[0]); end
        checks++; if (v[0] !== 1'b0) begin failures++; $display("FAIL reset_v got=%b exp=0", v[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
        checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done[0]); end
    endtask

    task automatic test_add();
        logic [15:0] tb_b [3] = '{16'h0001, 16'h0001, 16'h0001};
        logic [15:0] ta [3] = '{16'h000D, 16'hFFFF, 16'h7FFF};
        logic [17:0] e;
        logic [18:0] obs;
        int lat;
        for (int i = 0; i < 3; i++) begin
            load_b(tb_b[i]);
            q0.push_back(model(ta[i], tb_b[i], 1'b0));
            run_op(0, ta[i], 1'b0, lat, obs);
            e = q0.size() ? q0.pop_front() : 'x;
            checks++; if (lat !== 5) begin failures++; $display("FAIL add_latency[%0d] got=%0d exp=5", i, lat); end
            checks++; if (obs !== {1'b0, e}) begin failures++; $display("FAIL add[%0d] busy/v/co/sum got=%h exp=%h", i, obs, {1'b0, e}); end
        end
    endtask

    task automatic test_sub();
        logic [15:0] tb_b [2] = '{16'h0007, 16'h0003};
        logic [15:0] ta [2] = '{16'h0005, 16'h0009};
        logic [17:0] e;
        logic [18:0] obs;
        int lat;
        for (int i = 0; i < 2; i++) begin
            load_b(tb_b[i]);
            q0.push_back(model(ta[i], tb_b[i], 1'b1));
            run_op(0, ta[i], 1'b1, lat, obs);
            e = q0.size() ? q0.pop_front() : 'x;
            checks++; if (obs !== {1'b0, e}) begin failures++; $display("FAIL sub[%0d] busy/v/co/sum got=%h exp=%h (lat=%0d)", i, obs, {1'b0, e}, lat); end
        end
    endtask

    task automatic test_hold_run();
        logic [17:0] e;
        logic [18:0] obs;
        int lat;
        int ndone = 0;
        load_b(16'h0002);
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Run = 1'b1;
        SW = 16'h0010;
        Sub = 1'b0;
        q0.push_back(model(16'h0010, 16'h0002, 1'b0));
        for (int c = 1; c <= 22; c++) begin
            @(negedge Clk);
            LoadB = (c == 2);
            SW = (c == 2) ? 16'h0100 : 16'($urandom);
            if (done[0]) begin
                ndone++;
                e = q0.size() ? q0.pop_front() : 'x;
                checks++; if ({v[0], co[0], sum[0]} !== e) begin failures++; $display("FAIL hold_old_b got=%h exp=%h", {v[0], co[0], sum[0]}, e); end
            end
        end
        LoadB = 1'b0;
        checks++; if (ndone !== 1) begin failures++; $display("FAIL hold_done_count got=%0d exp=1", ndone); end
        q0.push_back(model(16'h0001, 16'h0100, 1'b0));
        run_op(0, 16'h0001, 1'b0, lat, obs);
        e = q0.size() ? q0.pop_front() : 'x;
        checks++; if (obs !== {1'b0, e}) begin failures++; $display("FAIL hold_new_b got=%h exp=%h", obs, {1'b0, e}); end
    endtask

    task automatic test_reset_mid();
        logic [17:0] e;
        logic [18:0] obs;
        int lat;
        int ndone = 0;
        load_b(16'h0005);
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Run = 1'b1;
        SW = 16'h0003;
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        LoadB = 1'b1;
        SW = 16'hFFFF;
        @(negedge Clk);
        Reset = 1'b0;
        LoadB = 1'b0;
        checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done[0]); end
        checks++; if (sum[0] !== 16'h0) begin failures++; $display("FAIL rstmid_sum got=%h exp=0000", sum[0]); end
        checks++; if (co[0] !== 1'b0) begin failures++; $display("FAIL rstmid_co got=%b exp=0", co[0]); end
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy[0]); end
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (done[0]) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        q0.push_back(model(16'h1234, 16'h0000, 1'b0));
        run_op(0, 16'h1234, 1'b0, lat, obs);
        e = q0.size() ? q0.pop_front() : 'x;
        checks++; if (obs !== {1'b0, e}) begin failures++; $display("FAIL rstmid_fresh got=%h exp=%h", obs, {1'b0, e}); end
    endtask

    task automatic test_sweep();
        logic [15:0] a, b;
        logic s;
        logic [17:0] e;
        int l1, l2;
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            load_b(b);
            q1.push_back(model(a, b, s));
            q2.push_back(model(a, b, s));
            @(negedge Clk);
            Run = 1'b0;
            @(negedge Clk);
            Run = 1'b1;
            SW = a;
            Sub = s;
            l1 = -1;
            l2 = -1;
            for (int c = 1; c <= 30; c++) begin
                @(negedge Clk);
                if (c == 1) begin
                    Run = 1'b0;
                    SW = 16'($urandom);
                end
                if (done[1]) begin
                    l1 = c;
                    e = q1.size() ? q1.pop_front() : 'x;
                    checks++; if ({v[1], co[1], sum[1]} !== e) begin failures++; $display("FAIL sweep_d1[%0d] got=%h exp=%h", i, {v[1], co[1], sum[1]}, e); end
                end
                if (done[2]) begin
                    l2 = c;
                    e = q2.size() ? q2.pop_front() : 'x;
                    checks++; if ({v[2], co[2], sum[2]} !== e) begin failures++; $display("FAIL sweep_d16[%0d] got=%h exp=%h", i, {v[2], co[2], sum[2]}, e); end
                end
                if (l1 >= 0 && l2 >= 0) break;
            end
            checks++; if (l1 !== 17) begin failures++; $display("FAIL sweep_d1_latency[%0d] got=%0d exp=17", i, l1); end
            checks++; if (l2 !== 2) begin failures++; $display("FAIL sweep_d16_latency[%0d] got=%0d exp=2", i, l2); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_hold_run();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_addsub_unit.md
# serial_addsub_unit

Parametrised multi-cycle adder/subtractor for the lab adder datapath; successor to the fixed 16-bit add-only toplevel. Operand B is loaded from the switches with LoadB. A rising edge on Run captures operand A from the switches and processes DIGIT bits per clock over WIDTH/DIGIT cycles. The result is registered Sum/CO, plus an optional signed-overflow flag. It sits between the debounced push-button/switch inputs and the LED/hex display drivers.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of DIGIT.
- DIGIT, 4: bits added per compute cycle. Range 1..WIDTH.
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- LoadB  in  1  active-high. Loads SW into operand register B on any cycle it is high.
- Run  in  1  active-high level. Only its rising edge starts an operation.
- Sub  in  1  mode, sampled on the Run edge: 0 = A+B, 1 = A−B.
- SW  in  WIDTH  switch operand.
- Sum  out  WIDTH  registered result.
- CO  out  1  registered carry-out. For Sub=1 it is the no-borrow flag.
- V  out  1  registered signed overflow. See Configuration.
- Busy  out  1  high while computing.
- Done  out  1  one-cycle pulse when Sum/CO/V update.

## Operation
- Reset values: Sum=0, CO=0, V=0, Busy=0, Done=0, B=0, state IDLE, Run edge register=0.
- Run edge detection: registered Run_q. An edge is Run=1 && Run_q=0. Run_q updates every cycle, in every state.
- States:
  - IDLE: on an edge, A_w←SW, B_w←(Sub ? ~B : B), carry←Sub, digit count←0, go to COMPUTE.
  - COMPUTE: each cycle adds the lowest DIGIT bits of A_w, B_w and carry. A_w and B_w shift right by DIGIT. The result digit shifts into the top of the working sum. count+1.
  - Last digit (count = WIDTH/DIGIT−1): Sum←completed working sum, CO←final carry, V←carry into MSB XOR carry out of MSB, Done←1, go to IDLE.
- All arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- Sum, CO and V hold their values between operations. They change only at completion or on Reset.
- LoadB is honoured in every state. A LoadB during COMPUTE updates B but not the in-flight B_w, so the running operation uses the snapshot.
- SW and Sub changes during COMPUTE have no effect.
- A Run edge during COMPUTE is ignored, not queued.
- Run held high starts exactly one operation. A new operation needs Run low for ≥1 cycle and then high again.
- Reset mid-COMPUTE: the operation is abandoned, all reset values apply, no Done.
- Reset and LoadB asserted together: Reset wins.

## Timing
- N = WIDTH/DIGIT.
- Edge sampled at clock edge E → Busy=1 in cycles E+1..E+N.
- Sum/CO/V are valid and Done=1 in cycle E+N+1. Busy=0 in that cycle.
- Latency is N+1 clocks from the edge-sampling edge. With defaults, N=4 and latency is 5.
- The earliest next start is a Run edge sampled in the Done cycle. That requires Run to be low in the cycle before it.
- LoadB affects B at the next clock edge. B is visible to an edge sampled one clock later.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: V is computed as above and registered at completion.
- SERIAL_ADDSUB_OVF_EN undefined: the V port remains but is tied to 0. The MSB carry tap logic is omitted.

## Structure
- Package addsub_pkg holds:
  - the state enum typedef (IDLE, COMPUTE);
  - a localparam function for the counter width, $clog2(WIDTH/DIGIT) with a minimum of 1.
- Sub-module digit_adder (parameter DIGIT): combinational DIGIT-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb_in (carry into the top bit, used for V).
  - Instantiated once in serial_addsub_unit.

## Test plan
- WIDTH=16, DIGIT=4: LoadB with SW=0x0001, then Run edge with SW=0x000D, Sub=0 → Done exactly 5 cycles later, Sum=0x000E, CO=0, V=0.
- B=0x0001, A=0xFFFF add → Sum=0x0000, CO=1, V=0. B=0x0001, A=0x7FFF add → Sum=0x8000, CO=0, V=1 with macro, V=0 without.
- Sub=1, B=0x0007, A=0x0005 → Sum=0xFFFE, CO=0. Then Sub=1, B=0x0003, A=0x0009 → Sum=0x0006, CO=1.
- Run held high 20 cycles → exactly one Done pulse. LoadB with SW=0x0100 at cycle E+2 → current result still uses the old B. The next operation uses 0x0100.
- Reset asserted at cycle E+2 → no Done, Sum=0, CO=0, Busy=0 next cycle. A fresh Run edge afterwards computes correctly (0 + A).
- Parameter sweep: DIGIT=1 (N=16, latency 17) and DIGIT=16 (N=1, latency 2) with random A/B/Sub → Sum/CO match a reference model.
